data_memory_unit: RTL
=====================

// Module: data_memory_unit
// PURPOSE
//  Word-addressed data memory serving lw/sw; sits directly downstream of the ALU.
//  Takes the ALU result as the byte address and rt as write data.
//  Runs a req/ready handshake with a programmable wait-state count, so the core can model slow memory.
//  Flags misaligned or out-of-range accesses instead of corrupting state.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words; must be a power of two
//  WAIT_STATES  2    extra cycles between acceptance and completion (0..15)
//  BASE_ADDR    0    byte address of word 0; must be word-aligned
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   asynchronous, active-high reset
//  req         in   1   access request; sampled only in IDLE
//  mem_read    in   1   request is a load (lw)
//  mem_write   in   1   request is a store (sw)
//  address     in   32  byte address (ALU result)
//  write_data  in   32  store data (rt)
//  read_data   out  32  load data; held until the next completed load or fault
//  ready       out  1   one-cycle completion pulse
//  busy        out  1   high from acceptance through the ready cycle
//  fault       out  1   one-cycle pulse, coincident with ready, on an illegal access
// BEHAVIOUR
//  Interface: one clock (clk); reset is asynchronous and active-high (reset).
//  Reset values: read_data=0, ready=0, busy=0, fault=0, FSM=IDLE, wait counter=0.
//  RAM contents are not reset.
//  FSM states:
//   - IDLE: req=1 latches address, write_data, mem_read, mem_write; goes to WAIT (WAIT_STATES>0) else DONE; busy=1 next cycle.
//   - WAIT: counter counts up to WAIT_STATES-1, then goes to DONE.
//   - DONE: performs the access, pulses ready, then returns to IDLE.
//  Latency: req accepted at edge N; ready high in cycle N+WAIT_STATES+1.
//  Back-to-back: a new req can be accepted on the first IDLE cycle after DONE.
//  req is ignored while busy=1; the master must hold req until busy is seen.
//  Address check: offset = address-BASE_ADDR (32-bit, unsigned). Legal iff offset[1:0]==0 and offset[31:2] < DEPTH_WORDS.
//   Offsets below BASE_ADDR wrap to large values and therefore fault.
//  Load: read_data = ram[offset[31:2]] in the DONE cycle.
//  Store: ram written at the DONE edge only; read_data unchanged.
//  Illegal requests pulse fault=1 with ready, make no RAM write, and set read_data=0. Illegal means any of:
//   - misaligned address
//   - out-of-range address
//   - mem_read and mem_write both set
//  req with neither mem_read nor mem_write set: no-op; ready pulses, fault=0, read_data held.
//  Reset mid-operation: the transaction aborts with no ready and no fault. A pending store is NOT written.
// STRUCTURE
//  Shared defines header (single_defs.v):
//   - `mem_state_idle/`mem_state_wait/`mem_state_done (2-bit encoding)
//   - `word_width 32
//  One sub-module, word_ram:
//   - synchronous-write, combinational-read array, DEPTH_WORDS x 32
//   - ports: clk, we, waddr, wdata, raddr, rdata
//  data_memory_unit holds the FSM, wait counter, address check and output registers.
// TESTING
//  1. WAIT_STATES=2. sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> ready 3 cycles after each accept; read_data=0xDEADBEEF, fault=0.
//  2. lw addr 0x13 (misaligned) -> ready+fault same cycle; read_data=0; RAM word 4 unchanged.
//  3. sw addr 4*DEPTH_WORDS (0x400) -> fault=1; a follow-up lw of every word shows no modification.
//  4. req held high and toggled while busy with different address -> only first access performed; ready exactly once.
//  5. Start sw 0x20 data 0x12345678, assert reset in the WAIT cycle -> no ready, no fault; after reset, lw 0x20 returns the prior value.
//  6. WAIT_STATES=0. Back-to-back lw 0x0, lw 0x4 -> ready in cycle after each accept; mem_read+mem_write together -> fault.

Source files
------------

// File: rtl/data_memory_unit_pkg.sv
// data_memory_unit_pkg: shared state encoding, word width and address legality helper
package data_memory_unit_pkg;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    function automatic logic addr_legal(input logic [31:0] offset, input int depth_words);
        return (offset[1:0] == 2'b00) && ({2'b00, offset[31:2]} < 32'(depth_words));
    endfunction

endpackage

// File: rtl/data_memory_unit_word_ram.sv
// word_ram: synchronous-write, combinational-read word array (contents not reset)
module word_ram
    import data_memory_unit_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [WORD_WIDTH-1:0] rdata
);

    logic [WORD_WIDTH-1:0] mem [DEPTH_WORDS];

    // write port: one word per clock when enabled
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_memory_unit.sv
// data_memory_unit: wait-stated lw/sw data memory with req/ready handshake and fault flagging
module data_memory_unit
    import data_memory_unit_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           address,
    input  logic [WORD_WIDTH-1:0] write_data,
    output logic [WORD_WIDTH-1:0] read_data,
    output logic                  ready,
    output logic                  busy,
    output logic                  fault
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);

    mem_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           addr_q, addr_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rd_q, rd_d, wr_q, wr_d;
    logic [WORD_WIDTH-1:0] read_data_q, read_data_d;
    logic                  ready_q, ready_d, busy_q, busy_d, fault_q, fault_d;

    logic                  acc, enter_done, bad, cur_rd, cur_wr, we;
    logic [31:0]           cur_addr, offset;
    logic [WORD_WIDTH-1:0] ram_rdata;

    // next-state logic; with zero wait states the access resolves straight from the request inputs
    always_comb begin
        acc         = (state_q == MEM_IDLE) && req;
        cur_addr    = (state_q == MEM_IDLE) ? address : addr_q;
        cur_rd      = (state_q == MEM_IDLE) ? mem_read : rd_q;
        cur_wr      = (state_q == MEM_IDLE) ? mem_write : wr_q;
        offset      = cur_addr - BASE_ADDR;
        bad         = (cur_rd || cur_wr) && (!addr_legal(offset, DEPTH_WORDS) || (cur_rd && cur_wr));
        enter_done  = (acc && WAIT_STATES == 0) || (state_q == MEM_WAIT && cnt_q == LAST_WAIT);
        state_d     = enter_done ? MEM_DONE : (acc || state_q == MEM_WAIT) ? MEM_WAIT : MEM_IDLE;
        cnt_d       = (state_q == MEM_WAIT && !enter_done) ? cnt_q + 4'd1 : 4'd0;
        addr_d      = acc ? address : addr_q;
        wdata_d     = acc ? write_data : wdata_q;
        rd_d        = acc ? mem_read : rd_q;
        wr_d        = acc ? mem_write : wr_q;
        busy_d      = acc || (state_q == MEM_WAIT);
        ready_d     = enter_done;
        fault_d     = enter_done && bad;
        read_data_d = !enter_done ? read_data_q : bad ? '0 : cur_rd ? ram_rdata : read_data_q;
        we          = (state_q == MEM_DONE) && wr_q && !bad;
    end

    // state, latched request and registered outputs; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= MEM_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            read_data_q <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            read_data_q <= read_data_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            fault_q     <= fault_d;
        end
    end

    word_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (offset[AW+1:2]),
        .wdata (wdata_q),
        .raddr (offset[AW+1:2]),
        .rdata (ram_rdata)
    );

    assign read_data = read_data_q;
    assign ready     = ready_q;
    assign busy      = busy_q;
    assign fault     = fault_q;

endmodule
